// File: rtl/sqrt_rr_arbiter_if.sv
// Bundles the requester and square-root unit signals of sqrt_rr_arbiter.
// master = arbiter side, slave = requesters plus square-root unit.
interface sqrt_rr_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 20,
  parameter int unsigned RW   = 10
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rsp_valid;
  logic [RW-1:0]      rsp_data;
  logic               rsp_err;
  logic               busy;
  logic [1:0]         arb_state;
  logic               sqrt_start;
  logic [DW-1:0]      sqrt_data_in;
  logic               sqrt_done;
  logic [RW-1:0]      sqrt_data_out;

  modport master (
    input  req, req_data, sqrt_done, sqrt_data_out,
    output gnt, rsp_valid, rsp_data, rsp_err, busy, arb_state,
           sqrt_start, sqrt_data_in
  );

  modport slave (
    output req, req_data, sqrt_done, sqrt_data_out,
    input  gnt, rsp_valid, rsp_data, rsp_err, busy, arb_state,
           sqrt_start, sqrt_data_in
  );
endinterface

// File: rtl/sqrt_rr_arbiter.sv
// Round-robin sequencer sharing one square-root unit among NREQ requesters,
// with a watchdog that aborts a response if the unit never signals done.
module sqrt_rr_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned DW      = 20,
  parameter int unsigned RW      = 10,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  sqrt_rr_arbiter_if.master   bus
);
  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   wdog_q, wdog_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [RW-1:0]   rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic            busy_q, busy_d;
  logic            start_q, start_d;
  logic [DW-1:0]   sqrt_data_in_q, sqrt_data_in_d;

  logic [PW-1:0]   sel_c;
  logic [PW-1:0]   idx_c;
  logic            found_c;

  // First pending requester at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    sel_c   = ptr_q;
    idx_c   = ptr_q;
    found_c = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx_c = PW'((32'(ptr_q) + i) % NREQ);
      if (!found_c && bus.req[idx_c]) begin
        sel_c   = idx_c;
        found_c = 1'b1;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    owner_d        = owner_q;
    wdog_d         = wdog_q;
    gnt_d          = '0;
    rsp_valid_d    = '0;
    rsp_data_d     = rsp_data_q;
    rsp_err_d      = 1'b0;
    start_d        = 1'b0;
    sqrt_data_in_d = sqrt_data_in_q;

    case (state_q)
      IDLE: begin
        if (found_c) begin
          owner_d        = sel_c;
          sqrt_data_in_d = bus.req_data[32'(sel_c) * DW +: DW];
          gnt_d          = NREQ'(1) << sel_c;
          start_d        = 1'b1;
          state_d        = LAUNCH;
        end
      end
      LAUNCH: begin
        wdog_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wdog_d = wdog_q + CW'(1);
        // A done seen with the watchdog still at 0 is left over from the previous operation.
        if (bus.sqrt_done && (wdog_q != '0)) begin
          rsp_data_d  = bus.sqrt_data_out;
          rsp_err_d   = 1'b0;
          rsp_valid_d = NREQ'(1) << owner_q;
          state_d     = RESP;
        end else if (wdog_q == CW'(TIMEOUT - 1)) begin
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = NREQ'(1) << owner_q;
          state_d     = RESP;
        end
      end
      RESP: begin
        ptr_d   = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      owner_q        <= '0;
      wdog_q         <= '0;
      gnt_q          <= '0;
      rsp_valid_q    <= '0;
      rsp_data_q     <= '0;
      rsp_err_q      <= 1'b0;
      busy_q         <= 1'b0;
      start_q        <= 1'b0;
      sqrt_data_in_q <= '0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      owner_q        <= owner_d;
      wdog_q         <= wdog_d;
      gnt_q          <= gnt_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
      rsp_err_q      <= rsp_err_d;
      busy_q         <= busy_d;
      start_q        <= start_d;
      sqrt_data_in_q <= sqrt_data_in_d;
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.busy         = busy_q;
  assign bus.arb_state    = state_q;
  assign bus.sqrt_start   = start_q;
  assign bus.sqrt_data_in = sqrt_data_in_q;
endmodule
